// File: rtl/clk_div_param.sv
// Programmable integer clock divider: N = active_ratio, updated through a
// four-phase handshake, with a glitch-free bypass mux. Define CLKDIV_ODD_DUTY50_EN for 50% duty on odd N.
module clk_div_param #(
    parameter int RATIO_W     = 12,
    parameter int RESET_RATIO = 2
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic               bypass,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               ratio_upd_req,
    output logic               ratio_upd_ack,
    output logic               ratio_err,
    output logic [RATIO_W-1:0] active_ratio,
    output logic               clkout
);

    typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, ACK = 2'd2} hs_state_t;

    localparam logic [RATIO_W-1:0] RST_N  = RATIO_W'(RESET_RATIO);
    localparam logic [RATIO_W-1:0] ONE_N  = RATIO_W'(1);
    localparam logic [RATIO_W-1:0] TWO_N  = RATIO_W'(2);
    localparam logic [RATIO_W:0]   ONE_W  = (RATIO_W + 1)'(1);

    logic [1:0]         bp_sync, req_sync;
    logic               bp_s, req_s;
    logic [RATIO_W-1:0] cnt, cnt_next, n_eff;
    logic [RATIO_W:0]   hi_thr;
    logic               period_start, upd_ok, load;
    logic               div_q, div_d, div_out, sel;
    hs_state_t          state, state_nx;

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            bp_sync  <= '0;
            req_sync <= '0;
        end else begin
            bp_sync  <= {bp_sync[0], bypass};
            req_sync <= {req_sync[0], ratio_upd_req};
        end
    end

    assign bp_s  = bp_sync[1];
    assign req_s = req_sync[1];

    assign cnt_next     = (cnt == active_ratio - ONE_N) ? '0 : cnt + ONE_N;
    assign period_start = (cnt_next == '0);
    assign upd_ok       = (ratio >= TWO_N);

    // The period that begins on the accepting edge already takes the new split.
    assign n_eff = (load && upd_ok) ? ratio : active_ratio;

`ifdef CLKDIV_ODD_DUTY50_EN
    // Odd N: div_q is high floor(N/2) cycles; the negedge copy adds half a cycle.
    assign hi_thr = {1'b0, n_eff} >> 1;
`else
    assign hi_thr = ({1'b0, n_eff} + ONE_W) >> 1;
`endif

    assign div_d = ({1'b0, cnt_next} < hi_thr);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: if (req_s) state_nx = PEND;
            PEND: if (period_start) begin
                state_nx = ACK;
                load     = 1'b1;
            end
            ACK:  if (!req_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            cnt          <= RST_N - ONE_N;
            div_q        <= 1'b0;
            sel          <= 1'b0;
            active_ratio <= RST_N;
            ratio_err    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_next;
            div_q <= div_d;
            if (period_start) sel <= bp_s;
            if (load) begin
                ratio_err <= ~upd_ok;
                if (upd_ok) active_ratio <= ratio;
            end
        end
    end

`ifdef CLKDIV_ODD_DUTY50_EN
    logic div_n;

    always_ff @(negedge clkin or negedge rstb) begin
        if (!rstb) div_n <= 1'b0;
        else       div_n <= div_q;
    end

    assign div_out = div_q | (active_ratio[0] & div_n);
`else
    assign div_out = div_q;
`endif

    assign ratio_upd_ack = (state == ACK);
    assign clkout        = sel ? clkin : div_out;

endmodule

// File: tb/tb_clk_div_param.sv
// Scoreboard bench for clk_div_param: stimulus pushes expected register
// snapshots and clkout high/low widths; monitors pop and compare.
`timescale 1ns/1ps
module tb_clk_div_param;

    logic        clkin = 1'b0;
    logic        rstb = 1'b0;
    logic        bypass = 1'b0;
    logic [11:0] ratio = 12'd0;
    logic        ratio_upd_req = 1'b0;
    logic        ratio_upd_ack, ratio_err, clkout;
    logic [11:0] active_ratio;

    int n_cmp = 0;
    int n_fail = 0;

    clk_div_param #(.RATIO_W(12), .RESET_RATIO(2)) dut (
        .clkin(clkin), .rstb(rstb), .bypass(bypass), .ratio(ratio),
        .ratio_upd_req(ratio_upd_req), .ratio_upd_ack(ratio_upd_ack),
        .ratio_err(ratio_err), .active_ratio(active_ratio), .clkout(clkout)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        string       tag;
        logic        ack;
        logic        err;
        logic [11:0] ar;
        bit          chk_co;
        logic        co;
    } snap_t;

    typedef struct {
        string tag;
        real   hi;
        real   lo;
    } per_t;

    snap_t snap_q[$];
    per_t  per_q[$];

    // Register snapshot monitor
    always @(negedge clkin) begin
        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            n_cmp++;
            if (ratio_upd_ack !== s.ack || ratio_err !== s.err || active_ratio !== s.ar ||
                (s.chk_co && clkout !== s.co)) begin
                n_fail++;
                $display("FAIL %s: ack=%b err=%b ar=%0d co=%b, expected ack=%b err=%b ar=%0d co=%b",
                         s.tag, ratio_upd_ack, ratio_err, active_ratio, clkout,
                         s.ack, s.err, s.ar, s.chk_co ? s.co : clkout);
            end
        end
    end

    // clkout period monitor and pulse-width tracker
    realtime t_rise = 0, t_fall = 0;
    bit      have_rise = 0;
    bit      wmon = 0, wm_r = 0, wm_f = 0;
    real     min_hi = 1.0e9, min_lo = 1.0e9;

    always @(negedge clkout) begin
        if (wmon && wm_r && ($realtime - t_rise) < min_hi) min_hi = $realtime - t_rise;
        t_fall = $realtime;
        wm_f   = wmon;
    end

    always @(posedge clkout) begin
        if (wmon && wm_f && ($realtime - t_fall) < min_lo) min_lo = $realtime - t_fall;
        if (have_rise && per_q.size() > 0) begin
            per_t e;
            real hi, lo;
            e  = per_q.pop_front();
            hi = t_fall - t_rise;
            lo = $realtime - t_fall;
            n_cmp++;
            if (hi > e.hi + 0.01 || hi < e.hi - 0.01 || lo > e.lo + 0.01 || lo < e.lo - 0.01) begin
                n_fail++;
                $display("FAIL %s: high=%0.2f low=%0.2f ns, expected high=%0.2f low=%0.2f ns",
                         e.tag, hi, lo, e.hi, e.lo);
            end
        end
        t_rise    = $realtime;
        have_rise = 1;
        wm_r      = wmon;
    end

    task automatic push_snap(input string tag, input logic ack, input logic err,
                             input logic [11:0] ar, input bit chk_co, input logic co);
        snap_t s;
        s.tag = tag; s.ack = ack; s.err = err; s.ar = ar; s.chk_co = chk_co; s.co = co;
        snap_q.push_back(s);
        @(negedge clkin); #1;
    endtask

    task automatic push_per(input string tag, input real hi, input real lo, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            per_t p;
            p.tag = tag; p.hi = hi; p.lo = lo;
            per_q.push_back(p);
        end
    endtask

    task automatic wait_per_empty(input string tag);
        int k;
        k = 0;
        while (per_q.size() > 0 && k < 3000) begin
            @(posedge clkin);
            k++;
        end
        if (per_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d periods outstanding, expected 0", tag, per_q.size());
            per_q.delete();
        end
    endtask

    task automatic chk(input string tag, input bit ok, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", tag, act, req);
        end
    endtask

    task automatic do_update(input string tag, input logic [11:0] r,
                             input logic exp_err, input logic [11:0] exp_ar);
        bit got;
        int n;
        ratio         = r;
        ratio_upd_req = 1'b1;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clkin); #1;
            if (ratio_upd_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk({tag, "_ack_timeout"}, 1'b0, 0, 1);
            ratio_upd_req = 1'b0;
            return;
        end
        // ack rises on a period start, so clkout has just gone high
        push_snap({tag, "_ack"}, 1'b1, exp_err, exp_ar, 1'b1, 1'b1);
        ratio_upd_req = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clkin); #1;
            n++;
            if (!ratio_upd_ack) break;
        end
        chk({tag, "_ack_fall_cycles"}, (n >= 1 && n <= 3 && !ratio_upd_ack), n, 3);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        push_snap("reset", 1'b0, 1'b0, 12'd2, 1'b1, 1'b0);
        repeat (3) @(negedge clkin);
        rstb = 1'b1;
        repeat (4) @(posedge clkin);
        push_per("div2", 10.0, 10.0, 3);
        wait_per_empty("div2");
        push_snap("div2_regs", 1'b0, 1'b0, 12'd2, 1'b0, 1'b0);

        // Valid update to 10
        repeat (3) @(posedge clkin); #2;
        do_update("upd10", 12'd10, 1'b0, 12'd10);
        push_per("div10", 50.0, 50.0, 2);
        wait_per_empty("div10");

        // Rejected update: ratio 1
        do_update("upd1", 12'd1, 1'b1, 12'd10);
        push_per("div10_after_err", 50.0, 50.0, 2);
        wait_per_empty("div10_after_err");
        push_snap("err_held", 1'b0, 1'b1, 12'd10, 1'b0, 1'b0);

        // Odd ratio 7, also clears the error
        do_update("upd7", 12'd7, 1'b0, 12'd7);
`ifdef CLKDIV_ODD_DUTY50_EN
        push_per("div7", 35.0, 35.0, 2);
`else
        push_per("div7", 40.0, 30.0, 2);
`endif
        wait_per_empty("div7");

        // Bypass toggles at random times with N = 13
        do_update("upd13", 12'd13, 1'b0, 12'd13);
        wait_per_empty("pre_bypass");
        wmon = 1;
        #($urandom_range(1, 130));
        bypass = 1'b1;
        repeat (40) @(posedge clkin);
        push_per("bypass", 5.0, 5.0, 3);
        wait_per_empty("bypass");
        #($urandom_range(1, 130));
        bypass = 1'b0;
        repeat (40) @(posedge clkin);
`ifdef CLKDIV_ODD_DUTY50_EN
        push_per("div13_resume", 65.0, 65.0, 2);
`else
        push_per("div13_resume", 70.0, 60.0, 2);
`endif
        wait_per_empty("div13_resume");
        wmon = 0;
        chk("bypass_min_high_ps", min_hi > 4.99, int'(min_hi * 1000.0), 5000);
        chk("bypass_min_low_ps", min_lo > 4.99, int'(min_lo * 1000.0), 5000);

        // Reset while PEND with ratio 20
        @(posedge clkout); #1;
        ratio         = 12'd20;
        ratio_upd_req = 1'b1;
        repeat (6) @(posedge clkin);
        #3;
        rstb = 1'b0;
        push_snap("abort_in_reset", 1'b0, 1'b0, 12'd2, 1'b1, 1'b0);
        ratio_upd_req = 1'b0;
        repeat (3) @(negedge clkin);
        rstb = 1'b1;
        repeat (4) @(posedge clkin);
        push_snap("abort_released", 1'b0, 1'b0, 12'd2, 1'b0, 1'b0);
        push_per("div2_after_abort", 10.0, 10.0, 2);
        wait_per_empty("div2_after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
